// File: rtl/vend_select_source.sv
// Vending machine source side of the display select path: coin accumulation, vend decision, hold countdown.
// Optional build macro VEND_TIMEOUT_SHOW_EN shows the remaining inactivity seconds on select_b while collecting.
module vend_select_source #(
  parameter int PRICE     = 7,
  parameter int HOLD_S    = 3,
  parameter int TIMEOUT_S = 5,
  parameter int TICK_DIV  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       cancel,
  output logic       select_control,
  output logic [3:0] select_a,
  output logic [3:0] select_b,
  output logic       dispense,
  output logic       refund,
  output logic [3:0] change_val,
  output logic       coin_reject
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [3:0] PRICE_L   = 4'(PRICE);
  localparam logic [3:0] HOLD_L    = 4'(HOLD_S);
  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT_S);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    total_q, total_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_q, sec_d;
  logic          sel_ctrl_q, sel_ctrl_d;
  logic [3:0]    sel_a_q, sel_a_d;
  logic [3:0]    sel_b_q, sel_b_d;
  logic          dispense_q, dispense_d;
  logic          refund_q, refund_d;
  logic [3:0]    change_q, change_d;
  logic          reject_q, reject_d;

  logic          coin_any;
  logic [3:0]    coin_val;
  logic          tick;

  assign coin_any = coin_1 | coin_5;
  assign coin_val = {3'b000, coin_1} + (coin_5 ? 4'd5 : 4'd0);
  assign tick     = (presc_q == TICK_LAST);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    presc_d    = tick ? {PW{1'b0}} : presc_q + PW'(1);
    sec_d      = sec_q;
    sel_ctrl_d = 1'b0;
    sel_a_d    = 4'd0;
    sel_b_d    = 4'd0;
    dispense_d = 1'b0;
    refund_d   = 1'b0;
    change_d   = change_q;
    reject_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        presc_d = {PW{1'b0}};
        sec_d   = 4'd0;
        if (coin_any) begin
          total_d = coin_val;
          state_d = (coin_val >= PRICE_L) ? S_VEND : S_COLLECT;
        end else begin
          total_d = 4'd0;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          refund_d = 1'b1;
          change_d = total_q;
          total_d  = 4'd0;
          reject_d = coin_any;
          state_d  = S_IDLE;
        end else if (coin_any) begin
          total_d = total_q + coin_val;
          presc_d = {PW{1'b0}};
          sec_d   = 4'd0;
          state_d = (total_d >= PRICE_L) ? S_VEND : S_COLLECT;
        end else if (tick) begin
          // The tick that would make elapsed reach TIMEOUT_S refunds on that same edge.
          if (sec_q >= TIMEOUT_L - 4'd1) begin
            refund_d = 1'b1;
            change_d = total_q;
            total_d  = 4'd0;
            state_d  = S_IDLE;
          end else begin
            sec_d = sec_q + 4'd1;
          end
        end else begin
          sec_d = sec_q;
        end
      end
      S_VEND: begin
        dispense_d = 1'b1;
        change_d   = total_q - PRICE_L;
        total_d    = 4'd0;
        presc_d    = {PW{1'b0}};
        sel_ctrl_d = 1'b1;
        sel_b_d    = HOLD_L;
        reject_d   = coin_any;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        reject_d   = coin_any;
        sel_ctrl_d = 1'b1;
        sel_b_d    = sel_b_q;
        if (tick) begin
          if (sel_b_q <= 4'd1) begin
            sel_ctrl_d = 1'b0;
            sel_b_d    = 4'd0;
            state_d    = S_IDLE;
          end else begin
            sel_b_d = sel_b_q - 4'd1;
          end
        end else begin
          sel_b_d = sel_b_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        total_d = 4'd0;
        presc_d = {PW{1'b0}};
        sec_d   = 4'd0;
      end
    endcase

    if (state_d == S_COLLECT) begin
      sel_a_d = total_d;
`ifdef VEND_TIMEOUT_SHOW_EN
      if ((TIMEOUT_L - sec_d) <= 4'd3) begin
        sel_ctrl_d = 1'b1;
        sel_b_d    = TIMEOUT_L - sec_d;
      end else begin
        sel_ctrl_d = 1'b0;
        sel_b_d    = 4'd0;
      end
`endif
    end else begin
      sel_a_d = 4'd0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      total_q    <= 4'd0;
      presc_q    <= {PW{1'b0}};
      sec_q      <= 4'd0;
      sel_ctrl_q <= 1'b0;
      sel_a_q    <= 4'd0;
      sel_b_q    <= 4'd0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      change_q   <= 4'd0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      sel_ctrl_q <= sel_ctrl_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
    end
  end

  assign select_control = sel_ctrl_q;
  assign select_a       = sel_a_q;
  assign select_b       = sel_b_q;
  assign dispense       = dispense_q;
  assign refund         = refund_q;
  assign change_val     = change_q;
  assign coin_reject    = reject_q;

endmodule
